// File: rtl/matmul_arb.sv
// Two-requester round-robin arbiter in front of a shared 3x3 matrix-multiply engine.
// Operands are latched at grant; the engine result is captured after LAT cycles once ready.
module matmul_arb #(
    parameter int W   = 7,
    parameter int LAT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req,
    input  logic [9*W-1:0]   i_a0,
    input  logic [9*W-1:0]   i_b0,
    input  logic [9*W-1:0]   i_a1,
    input  logic [9*W-1:0]   i_b1,
    output logic [1:0]       o_gnt,
    output logic [1:0]       o_done,
    output logic [9*W-1:0]   o_result,
    output logic             o_busy,
    output logic             o_mm_trigger,
    output logic [9*W-1:0]   o_mm_a,
    output logic [9*W-1:0]   o_mm_b,
    input  logic             i_mm_ready,
    input  logic [9*W-1:0]   i_mm_result
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] CNT_MAX = 4'(LAT - 1);

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [1:0]     done_q, done_d;
    logic [9*W-1:0] mm_a_q, mm_a_d;
    logic [9*W-1:0] mm_b_q, mm_b_d;
    logic [9*W-1:0] result_q, result_d;

    logic start;
    logic pick;
    logic cnt_hit;
    logic gidx;

    // The preferred requester wins a tie; a lone requester wins regardless of the pointer.
    assign pick    = i_req[ptr_q] ? ptr_q : ~ptr_q;
    assign start   = (|i_req) && i_mm_ready;
    assign cnt_hit = (cnt_q == CNT_MAX);
    assign gidx    = gnt_q[1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            mm_a_q   <= '0;
            mm_b_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            mm_a_q   <= mm_a_d;
            mm_b_q   <= mm_b_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_hit && i_mm_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        done_d   = done_q;
        mm_a_d   = mm_a_q;
        mm_b_d   = mm_b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    gnt_d  = pick ? 2'b10 : 2'b01;
                    mm_a_d = pick ? i_a1 : i_a0;
                    mm_b_d = pick ? i_b1 : i_b0;
                end
            end
            ISSUE: cnt_d = '0;
            WAIT: begin
                // Counter saturates; a stalled engine holds the block here with no timeout.
                if (!cnt_hit) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (i_mm_ready) begin
                    result_d = i_mm_result;
                    done_d   = gnt_q;
                end
            end
            DONE: begin
                done_d = '0;
                gnt_d  = '0;
                ptr_d  = ~gidx;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_mm_trigger = (state_q == ISSUE);
        o_busy       = (state_q != IDLE);
        o_gnt        = gnt_q;
        o_done       = done_q;
        o_mm_a       = mm_a_q;
        o_mm_b       = mm_b_q;
        o_result     = result_q;
    end

endmodule

// File: tb/tb_matmul_arb.sv
// Self-checking bench for matmul_arb: table-driven single jobs, a result scoreboard,
// and hand-written sequences for latency, arbitration, stall, reset and operand-latch cases.
module tb_matmul_arb;

    localparam int W   = 7;
    localparam int LAT = 2;
    localparam int MW  = 9 * W;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req;
    logic [MW-1:0] a0, b0, a1, b1;
    logic [1:0]    o_gnt, o_done;
    logic [MW-1:0] o_result, o_mm_a, o_mm_b;
    logic          o_busy, o_mm_trigger;
    logic          mm_ready;
    logic [MW-1:0] eng_res;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]    gnt;
        logic [MW-1:0] res;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [1:0]    req;
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [1:0]    exp_gnt;
        logic [MW-1:0] exp_res;
    } vec_t;
    vec_t tbl[8];

    matmul_arb #(.W(W), .LAT(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
        .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
        .o_gnt(o_gnt), .o_done(o_done), .o_result(o_result), .o_busy(o_busy),
        .o_mm_trigger(o_mm_trigger), .o_mm_a(o_mm_a), .o_mm_b(o_mm_b),
        .i_mm_ready(mm_ready), .i_mm_result(eng_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [MW-1:0] mm(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] r;
        logic [W-1:0]  acc;
        logic [W-1:0]  x, y;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = '0;
                for (int k = 0; k < 3; k++) begin
                    x   = a[(i*3+k)*W +: W];
                    y   = b[(k*3+j)*W +: W];
                    acc = W'(acc + W'(x * y));
                end
                r[(i*3+j)*W +: W] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] rnd_mat();
        return MW'({$urandom(), $urandom()});
    endfunction

    // Behavioural engine: computes at the trigger edge, result held until the next trigger.
    always @(posedge clk) begin
        if (!rst_n) eng_res <= '0;
        else if (o_mm_trigger) eng_res <= mm(o_mm_a, o_mm_b);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor and one-hot invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt_onehot", 128'($onehot0(o_gnt)), 128'd1);
            chk("done_onehot", 128'($onehot0(o_done)), 128'd1);
            if (o_done != 2'b00) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: got done=%b expected no completion", o_done);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("sb_done", 128'(o_done), 128'(e.gnt));
                    chk("sb_gnt", 128'(o_gnt), 128'(e.gnt));
                    chk("sb_result", 128'(o_result), 128'(e.res));
                end
            end
        end
    end

    task automatic push(input logic [1:0] g, input logic [MW-1:0] a, input logic [MW-1:0] b);
        sb_t e;
        e.gnt = g;
        e.res = mm(a, b);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = 2'b00;
        mm_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (o_done != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no o_done expected a pulse within 50 cycles", name);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [MW-1:0] ident, seq, sa0, sb0;
        rst_n = 1'b0;
        req = 2'b00;
        mm_ready = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        for (int i = 0; i < 8; i++) begin
            tbl[i].req = (i % 3 == 1 || i == 4) ? 2'b10 : 2'b01;
            tbl[i].a   = rnd_mat();
            tbl[i].b   = rnd_mat();
        end
        tbl[2].a = '1;
        tbl[2].b = '1;
        tbl[3].a = '0;
        for (int i = 0; i < 8; i++) begin
            tbl[i].exp_gnt = tbl[i].req;
            tbl[i].exp_res = mm(tbl[i].a, tbl[i].b);
        end

        ident = '0;
        seq   = '0;
        for (int k = 0; k < 9; k++) seq[k*W +: W] = W'(k + 1);
        for (int k = 0; k < 3; k++) ident[(k*3+k)*W +: W] = W'(1);

        do_reset();
        chk("rst_gnt", 128'(o_gnt), 128'd0);
        chk("rst_done", 128'(o_done), 128'd0);
        chk("rst_busy", 128'(o_busy), 128'd0);
        chk("rst_trigger", 128'(o_mm_trigger), 128'd0);
        chk("rst_mm_a", 128'(o_mm_a), 128'd0);
        chk("rst_mm_b", 128'(o_mm_b), 128'd0);
        chk("rst_result", 128'(o_result), 128'd0);

        // Basic latency: identity x 1..9
        a0 = ident;
        b0 = seq;
        push(2'b01, ident, seq);
        req = 2'b01;
        step();
        chk("lat_gnt", 128'(o_gnt), 128'd1);
        chk("lat_trigger_on", 128'(o_mm_trigger), 128'd1);
        chk("lat_busy", 128'(o_busy), 128'd1);
        chk("lat_mm_a", 128'(o_mm_a), 128'(ident));
        step();
        chk("lat_trigger_off", 128'(o_mm_trigger), 128'd0);
        step();
        chk("lat_done_early", 128'(o_done), 128'd0);
        step();
        chk("lat_done", 128'(o_done), 128'd1);
        chk("lat_result", 128'(o_result), 128'(seq));
        req = 2'b00;
        step();
        chk("lat_done_cleared", 128'(o_done), 128'd0);
        chk("lat_idle", 128'(o_busy), 128'd0);
        chk("lat_result_held", 128'(o_result), 128'(seq));

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].req == 2'b01) begin
                a0 = tbl[i].a; b0 = tbl[i].b; a1 = ~tbl[i].a; b1 = ~tbl[i].b;
            end else begin
                a1 = tbl[i].a; b1 = tbl[i].b; a0 = ~tbl[i].a; b0 = ~tbl[i].b;
            end
            push(tbl[i].exp_gnt, tbl[i].a, tbl[i].b);
            req = tbl[i].req;
            wait_done("tbl");
            chk("tbl_gnt", 128'(o_gnt), 128'(tbl[i].exp_gnt));
            chk("tbl_result", 128'(o_result), 128'(tbl[i].exp_res));
            req = 2'b00;
            step();
        end

        // Simultaneous requests: 0 first, one IDLE cycle, then 1
        do_reset();
        a0 = rnd_mat(); b0 = rnd_mat(); a1 = rnd_mat(); b1 = rnd_mat();
        push(2'b01, a0, b0);
        push(2'b10, a1, b1);
        req = 2'b11;
        wait_done("both0");
        chk("both_first", 128'(o_done), 128'd1);
        req = 2'b10;
        step();
        chk("both_idle_gap", 128'(o_busy), 128'd0);
        step();
        chk("both_second_gnt", 128'(o_gnt), 128'd2);
        wait_done("both1");
        chk("both_second", 128'(o_done), 128'd2);
        req = 2'b00;
        step();

        // Continuous requests alternate
        do_reset();
        a0 = rnd_mat(); b0 = rnd_mat(); a1 = rnd_mat(); b1 = rnd_mat();
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(2'b01, a0, b0);
            else push(2'b10, a1, b1);
        end
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_done("alt");
            chk("alt_done", 128'(o_done), (i % 2 == 0) ? 128'd1 : 128'd2);
        end
        req = 2'b00;
        step();

        // Engine stalls for 5 cycles
        do_reset();
        a0 = rnd_mat(); b0 = rnd_mat();
        push(2'b01, a0, b0);
        req = 2'b01;
        step();
        chk("stall_trigger", 128'(o_mm_trigger), 128'd1);
        mm_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_no_done", 128'(o_done), 128'd0);
            chk("stall_busy", 128'(o_busy), 128'd1);
        end
        mm_ready = 1'b1;
        step();
        chk("stall_done", 128'(o_done), 128'd1);
        req = 2'b00;
        step();

        // Reset during WAIT abandons the job
        do_reset();
        a0 = rnd_mat(); b0 = rnd_mat();
        req = 2'b01;
        step();
        step();
        chk("rstmid_busy", 128'(o_busy), 128'd1);
        rst_n = 1'b0;
        req = 2'b00;
        step();
        chk("rstmid_gnt", 128'(o_gnt), 128'd0);
        chk("rstmid_done", 128'(o_done), 128'd0);
        chk("rstmid_busy0", 128'(o_busy), 128'd0);
        chk("rstmid_trigger", 128'(o_mm_trigger), 128'd0);
        chk("rstmid_mm_a", 128'(o_mm_a), 128'd0);
        chk("rstmid_mm_b", 128'(o_mm_b), 128'd0);
        chk("rstmid_result", 128'(o_result), 128'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstmid_no_done", 128'(o_done), 128'd0);
        end
        push(2'b01, a0, b0);
        req = 2'b01;
        wait_done("rstmid_rerun");
        req = 2'b00;
        step();

        // Operands latched at grant; request dropped afterwards
        sa0 = rnd_mat(); sb0 = rnd_mat();
        a0 = sa0; b0 = sb0;
        push(2'b01, sa0, sb0);
        req = 2'b01;
        step();
        chk("latch_gnt", 128'(o_gnt), 128'd1);
        req = 2'b00;
        a0 = ~sa0;
        b0 = rnd_mat();
        wait_done("latch");
        chk("latch_done", 128'(o_done), 128'd1);
        chk("latch_result", 128'(o_result), 128'(mm(sa0, sb0)));
        step();
        step();

        chk("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_arb.md
MATMUL_ARB -- requirements
Module: matmul_arb

Interface
REQ-001 Parameter W, default 7: matrix element width in bits; every operand and result element is W bits.
REQ-002 Parameter LAT, default 2, legal range 1..15: minimum engine cycles from the trigger-cycle edge to a valid result.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 Port i_clk  input  1  rising-edge clock for all state.
REQ-005 Port i_rst_n  input  1  synchronous active-low reset.
REQ-006 Port i_req  input  2  per-requester request level; bit r is held high until o_done[r].
REQ-007 Ports i_a0, i_b0  input  9 x W each  requester-0 A and B matrices, row-major, index row*3+col.
REQ-008 Ports i_a1, i_b1  input  9 x W each  requester-1 A and B matrices, same layout.
REQ-009 Port o_gnt  output  2  one-hot grant; high from grant through completion.
REQ-010 Port o_done  output  2  one-cycle completion pulse to the granted requester.
REQ-011 Port o_result  output  9 x W  product of the last completed job; valid while o_done is high and held until the next capture.
REQ-012 Port o_busy  output  1  high whenever the state is not IDLE.
REQ-013 Port o_mm_trigger  output  1  start strobe to the shared 3x3 multiply engine.
REQ-014 Ports o_mm_a, o_mm_b  output  9 x W each  registered operands driven to the engine.
REQ-015 Port i_mm_ready  input  1  engine ready/idle indication.
REQ-016 Port i_mm_result  input  9 x W  engine result matrix.

Function
REQ-017 The block SHALL share one multiply engine between two requesters using states IDLE, ISSUE, WAIT and DONE.
REQ-018 IDLE: if any i_req bit is high and i_mm_ready=1, the block SHALL pick a requester by round-robin, set o_gnt, latch that requester's A/B into o_mm_a/o_mm_b, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-019 Round-robin: a pointer names the preferred requester; if both request, the preferred one wins; if one requests, it wins regardless of the pointer.
REQ-020 ISSUE: o_mm_trigger SHALL be high for exactly this one cycle; a wait counter SHALL clear; the next state SHALL be WAIT.
REQ-021 WAIT: the counter SHALL increment each cycle and saturate at LAT-1; when the counter equals LAT-1 and i_mm_ready=1, the block SHALL register i_mm_result into o_result, set o_done[granted]=1, and go to DONE.
REQ-022 WAIT with the counter at LAT-1 and i_mm_ready=0: the block SHALL remain in WAIT indefinitely with no timeout.
REQ-023 DONE: the block SHALL clear o_done and o_gnt, point round-robin at the non-granted requester, and return to IDLE.
REQ-024 Latency with i_mm_ready held at 1: if a request is sampled at edge 0, the trigger is high after edge 0 and o_done is high in the cycle after edge 1+LAT.
REQ-025 Operands SHALL be sampled only at the grant edge; later changes to i_a*/i_b* or a drop of i_req SHALL NOT affect the job in flight, and o_done SHALL still pulse.
REQ-026 i_req still high in the cycle after o_done SHALL be treated as a new request subject to round-robin; the minimum idle gap between jobs is one cycle (the IDLE cycle).
REQ-027 o_result SHALL be passed through unmodified; the engine truncates to W bits, and this block performs no arithmetic.
REQ-028 At most one o_gnt bit and one o_done bit SHALL be high at any time, and o_done SHALL coincide with the matching o_gnt bit.

Reset
REQ-029 On i_rst_n=0 at a clock edge, the block SHALL set the state to IDLE, the pointer to requester 0, the counter to 0, and o_gnt, o_done, o_mm_trigger, o_mm_a, o_mm_b and o_result to all zeros; o_busy SHALL then read 0.
REQ-030 Reset mid-job SHALL abandon the job with no o_done pulse; the requester must keep or re-raise i_req to be served.

Verification
REQ-031 Reset released, i_req=2'b01, A0=identity, B0 elements 1..9, ready=1 -> o_gnt=01, one trigger pulse, o_done=01 after edge 3 (LAT=2), o_result=1..9.
REQ-032 Both requesters raise i_req in the same cycle after reset -> requester 0 served first, then requester 1 with a one-cycle IDLE gap between them; both o_result values match the golden model mod 2^W.
REQ-033 Both requests held high continuously -> grants alternate 01,10,01,10 with no starvation.
REQ-034 i_mm_ready forced low for 5 cycles during WAIT -> no capture and no o_done until ready returns; the capture occurs on the first edge with ready=1.
REQ-035 Reset asserted during WAIT -> the next cycle shows all outputs zero, no o_done, state IDLE; a re-raised request completes normally.
REQ-036 Requester drops i_req and changes A/B after the grant -> the result reflects the operands latched at grant, and o_done still pulses.
